// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential wide adder: slice width, FSM encoding
// and the slice-index width helper.
package cla_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Index width for a slice counter over `words` slices, never narrower than one bit.
    function automatic int IDX_W(input int words);
        int w;
        w = $clog2(words);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead
// level across the group generate/propagate terms.
module cla_adder16 (
    output logic [15:0] sum,
    output logic        carry_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in
);

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  pg_s;
    logic [4:0]  gc_s;

    // Bit and group generate/propagate, group carries, then in-group carries.
    always_comb begin
        g_s  = a & b;
        p_s  = a ^ b;
        gg_s = 4'b0000;
        pg_s = 4'b0000;
        c_s  = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            pg_s[k] = &p_s[4*k +: 4];
        end
        gc_s[0] = carry_in;
        gc_s[1] = gg_s[0] | (pg_s[0] & carry_in);
        gc_s[2] = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & carry_in);
        gc_s[3] = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
                | (pg_s[2] & pg_s[1] & pg_s[0] & carry_in);
        gc_s[4] = gg_s[3] | (pg_s[3] & gg_s[2]) | (pg_s[3] & pg_s[2] & gg_s[1])
                | (pg_s[3] & pg_s[2] & pg_s[1] & gg_s[0])
                | (pg_s[3] & pg_s[2] & pg_s[1] & pg_s[0] & carry_in);
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = gc_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
        end
        sum       = p_s ^ c_s;
        carry_out = gc_s[4];
    end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-precision adder that feeds one 16-bit CLA a slice per cycle, LS first,
// chaining the carry through a register. Optional subtract: CLA_SEQ_SUB_EN.
module cla_wide_add_seq
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    input  logic                    carry_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    carry_out,
    output logic                    busy
);

    localparam int W  = WORD_W * WORDS;
    localparam int IW = IDX_W(WORDS);
    localparam int BW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    seq_state_t    state_r;
    seq_state_t    state_nxt_s;
    logic [IW-1:0] idx_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry_r;
    logic [W-1:0]  sum_r;
    logic          carry_out_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          sub_r;
    logic [BW-1:0] base_s;
    logic [15:0]   slice_a_s;
    logic [15:0]   slice_b_s;
    logic [15:0]   add_sum_s;
    logic          add_co_s;
    logic          sub_in_s;

`ifdef CLA_SEQ_SUB_EN
    assign sub_in_s = sub;
`else
    assign sub_in_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Slice selection; B is inverted for subtraction (sub_r is tied low without the feature).
    always_comb begin
        base_s    = BW'({idx_r, 4'b0000});
        slice_a_s = a_r[base_s +: WORD_W];
        slice_b_s = b_r[base_s +: WORD_W] ^ {WORD_W{sub_r}};
    end

    cla_adder16 u_adder (
        .sum       (add_sum_s),
        .carry_out (add_co_s),
        .a         (slice_a_s),
        .b         (slice_b_s),
        .carry_in  (carry_r)
    );

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture on accept, then one slice per RUN cycle with the carry chained in carry_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r       <= {IW{1'b0}};
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            carry_r     <= 1'b0;
            sub_r       <= 1'b0;
            sum_r       <= {W{1'b0}};
            carry_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub_in_s;
                        carry_r <= carry_in ^ sub_in_s;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[base_s +: WORD_W] <= add_sum_s;
                    carry_r                 <= add_co_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r       <= {IW{1'b0}};
                        carry_out_r <= add_co_s;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                ST_DONE: begin
                    idx_r <= {IW{1'b0}};
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule
